// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle RISC-V main control unit.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_PCOFF = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
  } ctrl_word_t;

  // States whose exit completes an instruction.
  function automatic logic retires(input state_t s);
    return (s == S_MEM_WB) || (s == S_MEM_WRITE) || (s == S_R_WB) || (s == S_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath boundary: opcode in, control lines and status out.
interface multicycle_control_if #(
  parameter int INSTRET_W = 32
);
  logic [6:0]           opcode;
  logic [1:0]           ALUOp;
  logic [1:0]           ALUSrcB;
  logic                 ALUSrcA;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 IorD;
  logic                 IRWrite;
  logic                 MemtoReg;
  logic                 RegWrite;
  logic                 PCWrite;
  logic                 PCWriteCond;
  logic                 PCSource;
  logic [3:0]           state;
  logic                 halted;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  opcode,
    output ALUOp, ALUSrcB, ALUSrcA, MemRead, MemWrite, IorD, IRWrite,
           MemtoReg, RegWrite, PCWrite, PCWriteCond, PCSource,
           state, halted, instret
  );

  modport slave (
    output opcode,
    input  ALUOp, ALUSrcB, ALUSrcA, MemRead, MemWrite, IorD, IRWrite,
           MemtoReg, RegWrite, PCWrite, PCWriteCond, PCSource,
           state, halted, instret
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Moore output decode: maps the current state to the full control word.
module control_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        // PC takes PC+4 from ALUOut while the ALU forms the branch target.
        ctrl.alu_src_b = SRCB_PCOFF;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath: sequencing, retire count, reset gating.
module multicycle_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t               state_reg;
  state_t               state_next;
  logic [INSTRET_W-1:0] instret_reg;
  ctrl_word_t           ctrl_raw;
  ctrl_word_t           ctrl;

  control_decode u_decode (
    .state (state_reg),
    .ctrl  (ctrl_raw)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LD, OP_SD: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        case (bus.opcode)
          OP_LD:   state_next = S_MEM_READ;
          OP_SD:   state_next = S_MEM_WRITE;
          default: state_next = S_HALT;
        endcase
      end
      S_MEM_READ:  state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = S_FETCH;
      S_EXECUTE:   state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      default:     state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retires(state_reg)) begin
        instret_reg <= instret_reg + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Forcing the word to zero during reset kills any write in the current cycle.
  assign ctrl = reset ? '0 : ctrl_raw;

  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.state       = state_reg;
  assign bus.halted      = (state_reg == S_HALT);
  assign bus.instret     = instret_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed plus randomized bench for multicycle_control against a per-instruction reference model.
module tb_multicycle_control;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int unsigned model_instret;

  multicycle_control_if #(.INSTRET_W(32)) bus ();

  multicycle_control #(.INSTRET_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [14:0] obs_ctrl();
    return {bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, bus.MemRead, bus.MemWrite, bus.IorD,
            bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.PCWrite, bus.PCWriteCond, bus.PCSource};
  endfunction

  // Control lines listed for each state number; everything unlisted is 0.
  function automatic logic [14:0] exp_ctrl(input int s);
    logic [1:0] aluop, srcb;
    logic srca, mr, mw, iord, irw, m2r, rw, pcw, pcwc, pcs;
    aluop = 2'b00; srcb = 2'b00;
    {srca, mr, mw, iord, irw, m2r, rw, pcw, pcwc, pcs} = '0;
    case (s)
      0: begin mr = 1; irw = 1; srcb = 2'b01; end
      1: begin srcb = 2'b11; pcw = 1; pcs = 1; end
      2: begin srca = 1; srcb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iord = 1; end
      6: begin srca = 1; aluop = 2'b10; end
      7: begin rw = 1; end
      8: begin srca = 1; aluop = 2'b01; pcwc = 1; pcs = 1; end
      default: ;
    endcase
    return {aluop, srcb, srca, mr, mw, iord, irw, m2r, rw, pcw, pcwc, pcs};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction from FETCH. stop_at >= 0 returns early, leaving the DUT
  // mid-cycle in the stop_at-th state of the sequence.
  task automatic run_instr(input logic [6:0] op, input int stop_at);
    int seq[5];
    int len;
    logic legal;
    legal = 1'b1;
    case (op)
      LD:      begin seq = '{0, 1, 2, 3, 4}; len = 5; end
      SD:      begin seq = '{0, 1, 2, 5, 0}; len = 4; end
      RT:      begin seq = '{0, 1, 6, 7, 0}; len = 4; end
      BEQ:     begin seq = '{0, 1, 8, 0, 0}; len = 3; end
      default: begin seq = '{0, 1, 0, 0, 0}; len = 2; legal = 1'b0; end
    endcase
    bus.opcode = op;
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) return;
      check($sformatf("op%b_c%0d_state", op, i), 64'(bus.state), 64'(seq[i]));
      check($sformatf("op%b_c%0d_ctrl", op, i), 64'(obs_ctrl()), 64'(exp_ctrl(seq[i])));
      check($sformatf("op%b_c%0d_instret", op, i), 64'(bus.instret), 64'(model_instret));
      check($sformatf("op%b_c%0d_halted", op, i), 64'(bus.halted), 64'(0));
      step();
    end
    if (legal) model_instret++;
    $display("[TB] instr op=%b len=%0d instret_model=%0d", op, len, model_instret);
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      check("halt_state", 64'(bus.state), 64'(15));
      check("halt_flag", 64'(bus.halted), 64'(1));
      check("halt_ctrl", 64'(obs_ctrl()), 64'(0));
      check("halt_instret", 64'(bus.instret), 64'(model_instret));
      step();
    end
  endtask

  // Assert reset mid-cycle, verify gating, release after one edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_rst_ctrl"}, 64'(obs_ctrl()), 64'(0));
    step();
    check({tag, "_rst_instret"}, 64'(bus.instret), 64'(0));
    reset = 1'b0;
    #1;
    model_instret = 0;
    check({tag, "_post_state"}, 64'(bus.state), 64'(0));
    $display("[TB] reset %s", tag);
  endtask

  initial begin
    logic [6:0] ops[4];
    logic [6:0] op;
    int r;
    n_tests = 0;
    n_fail = 0;
    model_instret = 0;
    ops = '{LD, SD, RT, BEQ};
    reset = 1'b1;
    bus.opcode = 7'd0;

    step();
    step();
    check("reset_ctrl", 64'(obs_ctrl()), 64'(0));
    check("reset_instret", 64'(bus.instret), 64'(0));
    reset = 1'b0;
    #1;
    check("first_fetch_state", 64'(bus.state), 64'(0));
    check("first_fetch_ctrl", 64'(obs_ctrl()), 64'(exp_ctrl(0)));

    run_instr(LD, -1);
    check("ld_instret_one", 64'(bus.instret), 64'(1));
    run_instr(SD, -1);
    run_instr(RT, -1);
    run_instr(BEQ, -1);
    check("rt_beq_instret", 64'(bus.instret), 64'(4));

    run_instr(7'b1111111, -1);
    hold_halt(22);
    do_reset("after_halt");

    run_instr(SD, 3);
    check("sd_in_state5", 64'(bus.state), 64'(5));
    check("sd_memwrite_pre", 64'(bus.MemWrite), 64'(1));
    reset = 1'b1;
    #1;
    check("sd_memwrite_suppressed", 64'(bus.MemWrite), 64'(0));
    step();
    reset = 1'b0;
    #1;
    model_instret = 0;
    check("sd_rst_state", 64'(bus.state), 64'(0));
    check("sd_rst_instret", 64'(bus.instret), 64'(0));
    run_instr(RT, -1);

    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) begin
        run_instr(ops[$urandom_range(0, 3)], -1);
      end else if (r == 8) begin
        run_instr(ops[$urandom_range(0, 3)], int'($urandom_range(1, 2)));
        do_reset("rand_mid");
      end else begin
        op = 7'($urandom);
        if (op == LD || op == SD || op == RT || op == BEQ) op = 7'b0000000;
        run_instr(op, -1);
        hold_halt(int'($urandom_range(1, 5)));
        do_reset("rand_halt");
      end
    end
    check("final_instret", 64'(bus.instret), 64'(model_instret));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
